// File: rtl/mux5_2_reg.sv
// Field-select mux: picks one WIDTH-bit field of a packed word by index, with a
// combinational result plus a registered copy. Out-of-range selects give zero.
module mux5_2_reg #(
    parameter int N_INPUTS = 5,
    parameter int WIDTH    = 2,
    parameter int SEL_W    = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_INPUTS*WIDTH-1:0] a,
    input  logic [SEL_W-1:0]          s,
    output logic [WIDTH-1:0]          y,
    output logic                      sel_invalid,
    output logic [WIDTH-1:0]          y_q,
    output logic                      sel_invalid_q
);

    logic [WIDTH-1:0] y_d;
    logic             sel_invalid_d;

    // Defaults cover every select not matched below, so s >= N_INPUTS yields zero.
    always_comb begin
        y_d           = '0;
        sel_invalid_d = 1'b1;
        for (int k = 0; k < N_INPUTS; k++) begin
            if (s == SEL_W'(k)) begin
                y_d           = a[k*WIDTH +: WIDTH];
                sel_invalid_d = 1'b0;
            end
        end
    end

    assign y           = y_d;
    assign sel_invalid = sel_invalid_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q           <= '0;
            sel_invalid_q <= 1'b0;
        end else begin
            y_q           <= y_d;
            sel_invalid_q <= sel_invalid_d;
        end
    end

endmodule

// File: tb/tb_mux5_2_reg.sv
// Directed bench for mux5_2_reg: field sweep, out-of-range selects, random
// combinational comparison against a reference model, register latency and async reset.
module tb_mux5_2_reg;

    logic       clk;
    logic       rst_n;
    logic [9:0] a;
    logic [2:0] s;
    logic [1:0] y;
    logic       sel_invalid;
    logic [1:0] y_q;
    logic       sel_invalid_q;

    int checks;
    int errors;

    mux5_2_reg #(.N_INPUTS(5), .WIDTH(2), .SEL_W(3)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .a             (a),
        .s             (s),
        .y             (y),
        .sel_invalid   (sel_invalid),
        .y_q           (y_q),
        .sel_invalid_q (sel_invalid_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [1:0] model_y(input logic [9:0] av, input logic [2:0] sv);
        case (sv)
            3'd0:    model_y = av[1:0];
            3'd1:    model_y = av[3:2];
            3'd2:    model_y = av[5:4];
            3'd3:    model_y = av[7:6];
            3'd4:    model_y = av[9:8];
            default: model_y = 2'b00;
        endcase
    endfunction

    function automatic logic model_inv(input logic [2:0] sv);
        model_inv = (sv > 3'd4);
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    initial begin
        logic [1:0] exp_sweep [5];
        checks = 0;
        errors = 0;
        exp_sweep[0] = 2'b10;
        exp_sweep[1] = 2'b00;
        exp_sweep[2] = 2'b11;
        exp_sweep[3] = 2'b01;
        exp_sweep[4] = 2'b10;

        // Reset state
        rst_n = 1'b0;
        a     = 10'b0;
        s     = 3'd0;
        #3;
        chk("reset_y_q", {6'b0, y_q}, 8'd0);
        chk("reset_inv_q", {7'b0, sel_invalid_q}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // In-range sweep
        a = 10'b1001110010;
        for (int i = 0; i < 5; i++) begin
            s = 3'(i);
            #1;
            chk($sformatf("sweep_y_s%0d", i), {6'b0, y}, {6'b0, exp_sweep[i]});
            chk($sformatf("sweep_inv_s%0d", i), {7'b0, sel_invalid}, 8'd0);
        end

        // Out-of-range selects
        a = 10'b1111111111;
        for (int i = 5; i < 8; i++) begin
            s = 3'(i);
            #1;
            chk($sformatf("oor_y_s%0d", i), {6'b0, y}, 8'd0);
            chk($sformatf("oor_inv_s%0d", i), {7'b0, sel_invalid}, 8'd1);
        end

        // Random combinational comparison
        for (int i = 0; i < 1024; i++) begin
            a = 10'($urandom);
            s = 3'($urandom);
            #1;
            chk("rand_y", {6'b0, y}, {6'b0, model_y(a, s)});
            chk("rand_inv", {7'b0, sel_invalid}, {7'b0, model_inv(s)});
        end

        // Registered latency
        @(negedge clk);
        a = 10'b0000001100;
        s = 3'd1;
        @(posedge clk);
        #1;
        chk("lat_y_q_first", {6'b0, y_q}, 8'b11);
        chk("lat_inv_q_first", {7'b0, sel_invalid_q}, 8'd0);
        s = 3'd6;
        #1;
        chk("lat_y_comb_s6", {6'b0, y}, 8'd0);
        chk("lat_y_q_hold", {6'b0, y_q}, 8'b11);
        chk("lat_inv_q_hold", {7'b0, sel_invalid_q}, 8'd0);
        @(posedge clk);
        #1;
        chk("lat_y_q_s6", {6'b0, y_q}, 8'd0);
        chk("lat_inv_q_s6", {7'b0, sel_invalid_q}, 8'd1);

        // Async reset mid-cycle
        s = 3'd1;
        @(posedge clk);
        #1;
        chk("pre_rst_y_q", {6'b0, y_q}, 8'b11);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_y_q", {6'b0, y_q}, 8'd0);
        chk("arst_inv_q", {7'b0, sel_invalid_q}, 8'd0);
        chk("arst_y_comb", {6'b0, y}, 8'b11);
        chk("arst_inv_comb", {7'b0, sel_invalid}, 8'd0);
        @(posedge clk);
        #1;
        chk("arst_hold_y_q", {6'b0, y_q}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_no_capture_y_q", {6'b0, y_q}, 8'd0);
        @(posedge clk);
        #1;
        chk("rel_capture_y_q", {6'b0, y_q}, 8'b11);
        chk("rel_capture_inv_q", {7'b0, sel_invalid_q}, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux5_2_reg.md
# mux5_2_reg

Selects one 2-bit field out of a 10-bit packed word using a 3-bit select. It provides a combinational output and a registered copy of that output. Select values 5–7 are out of range and force the output to zero. It is the datapath field-select primitive, feeding both combinational consumers and clocked downstream stages.

## Interface
- `N_INPUTS`, default 5: number of selectable fields.
- `WIDTH`, default 2: bits per field.
- `SEL_W`, default 3: select width; must satisfy 2^SEL_W ≥ N_INPUTS.
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `a`, input, N_INPUTS*WIDTH (10): packed fields; field k = `a[k*WIDTH+WIDTH-1 : k*WIDTH]`.
- `s`, input, SEL_W (3): field select, unsigned.
- `y`, output, WIDTH (2): combinational selected field.
- `sel_invalid`, output, 1: combinational flag, 1 when s ≥ N_INPUTS.
- `y_q`, output, WIDTH (2): `y` registered on `clk`.
- `sel_invalid_q`, output, 1: `sel_invalid` registered on `clk`.

## Operation
- Field mapping: s=0 → `a[1:0]`, s=1 → `a[3:2]`, s=2 → `a[5:4]`, s=3 → `a[7:6]`, s=4 → `a[9:8]`.
- If s ≥ N_INPUTS (5, 6 or 7), `y` = all zeros and `sel_invalid` = 1. Otherwise `sel_invalid` = 0.
- `y` and `sel_invalid` are pure combinational functions of `a` and `s`.
  - No latches; every select value is fully decoded.
  - Independent of `clk` and `rst_n`.
- If `a` or `s` carries X/Z, the output for that condition is don't-care.
  - Exception: known in-range inputs must produce known outputs; `y` must be 2-state-correct under the `===` comparison.
- Register stage:
  - `y_q` and `sel_invalid_q` capture `y` and `sel_invalid` on each rising `clk`.
  - There is no enable; the register updates every cycle.
- Generic behaviour: for any N_INPUTS and WIDTH, field k occupies bits `[k*WIDTH +: WIDTH]`. Select values ≥ N_INPUTS yield zero and set the flag.

## Timing
- Combinational path:
  - `y` and `sel_invalid` settle within the same delta/propagation window as an `a` or `s` change.
  - They must be valid 1 ns after any input change in simulation.
  - Zero cycles of latency.
- Registered path: `y_q` and `sel_invalid_q` have 1-cycle latency; they reflect inputs sampled at the preceding rising `clk`.
- Reset:
  - `rst_n` = 0 immediately, with no clock required, forces `y_q` = 2'b00 and `sel_invalid_q` = 0.
  - Both are held at these values while `rst_n` is low.
  - The first capture occurs at the first rising `clk` after `rst_n` deasserts.
- Reset does not affect `y` or `sel_invalid`.
- Reset asserted mid-operation clears the registered outputs asynchronously. The combinational outputs keep tracking inputs.

## Test plan
- Exhaustive in-range sweep with a = 10'b1001110010:
  - s = 0 → y = 10.
  - s = 1 → y = 00.
  - s = 2 → y = 11.
  - s = 3 → y = 01.
  - s = 4 → y = 10.
  - `sel_invalid` = 0 in all five cases.
- Out-of-range: a = 10'b1111111111, s = 5, 6, 7 → y = 00 and `sel_invalid` = 1 each time.
- Random combinational check:
  - 1024 iterations; each applies random a and s, then waits 1 ns.
  - On every change of a or s, check `y` against the behavioural model with `===`.
  - Required: zero mismatches.
- Registered latency:
  - Apply a = 10'b0000001100 and s = 1, then one rising clk → y_q = 11, sel_invalid_q = 0.
  - Change s to 6 → y_q stays 11 until the next edge, then y_q = 00 and sel_invalid_q = 1.
- Async reset:
  - With y_q = 11, drive rst_n low between clock edges → y_q = 00 and sel_invalid_q = 0 immediately; `y` unchanged.
  - Release rst_n → outputs update at the next rising clk.
